jk_monitor: RTL and testbench



---
 rtl/jk_pkg.sv | 23 ++
 rtl/sat_counter.sv | 27 ++
 rtl/jk_monitor.sv | 105 ++++++++++
 tb/tb_jk_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: {j,k} input encodings and the next-state model.
// Reused by the flop model, the monitor and later JK blocks.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  function automatic logic jk_next(input logic [1:0] jk, input logic q);
    logic w_next;
    w_next = q;
    unique case (jk)
      JK_HOLD: w_next = q;
      JK_RST:  w_next = 1'b0;
      JK_SET:  w_next = 1'b1;
      JK_TGL:  w_next = ~q;
      default: w_next = q;
    endcase
    return w_next;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
// Clear takes priority over an increment in the same cycle.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/jk_monitor.sv
// Observer for a single JK flop: registered edge pulses, toggle count, last high-run
// length and a sticky divergence flag against the cycle-accurate JK model.
module jk_monitor
  import jk_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [LEN_W-1:0] high_len,
  output logic             mismatch,
  output logic [CNT_W-1:0] mis_cnt
);

  logic             r_j_s;
  logic             r_k_s;
  logic             r_q_s;
  logic             r_valid;
  logic             r_rise;
  logic             r_fall;
  logic [LEN_W-1:0] r_run;
  logic [LEN_W-1:0] r_high_len;
  logic             r_mismatch;

  logic w_exp;
  logic w_rise_ev;
  logic w_fall_ev;
  logic w_tgl_ev;
  logic w_mis_ev;

  // Events only count once a baseline sample exists (r_valid).
  assign w_exp     = jk_next({r_j_s, r_k_s}, r_q_s);
  assign w_rise_ev = r_valid & q & ~r_q_s;
  assign w_fall_ev = r_valid & ~q & r_q_s;
  assign w_tgl_ev  = w_rise_ev | w_fall_ev;
  assign w_mis_ev  = r_valid & (q ^ w_exp);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_j_s      <= 1'b0;
      r_k_s      <= 1'b0;
      r_q_s      <= 1'b0;
      r_valid    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_run      <= '0;
      r_high_len <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_j_s   <= j;
      r_k_s   <= k;
      r_q_s   <= q;
      r_valid <= 1'b1;
      r_rise  <= w_rise_ev;
      r_fall  <= w_fall_ev;
      if (clr) begin
        r_run      <= '0;
        r_high_len <= '0;
        r_mismatch <= 1'b0;
      end else if (r_valid) begin
        if (q) begin
          if (r_run != {LEN_W{1'b1}}) r_run <= r_run + 1'b1;
        end else begin
          if (w_fall_ev) r_high_len <= r_run;
          r_run <= '0;
        end
        if (w_mis_ev) r_mismatch <= 1'b1;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_toggle_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .inc  (w_tgl_ev),
    .cnt  (toggle_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_mis_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .inc  (w_mis_ev),
    .cnt  (mis_cnt)
  );

  assign rise     = r_rise;
  assign fall     = r_fall;
  assign high_len = r_high_len;
  assign mismatch = r_mismatch;

endmodule

// File: tb/tb_jk_monitor.sv
// Bench for jk_monitor: a default-width and a 3-bit instance share stimulus and are
// compared every cycle against a sample-history reference model.
module tb_jk_monitor;

  logic clk = 1'b0;
  logic rstn = 1'b0, j = 1'b0, k = 1'b0, q = 1'b0, clr = 1'b0;

  logic       rise8, fall8, mis8;
  logic [7:0] tog8, hl8, mc8;
  logic       rise3, fall3, mis3;
  logic [2:0] tog3, hl3, mc3;

  always #5 clk = ~clk;

  jk_monitor #(.CNT_W(8), .LEN_W(8)) dut8 (
    .clk(clk), .rstn(rstn), .j(j), .k(k), .q(q), .clr(clr),
    .rise(rise8), .fall(fall8), .toggle_cnt(tog8), .high_len(hl8),
    .mismatch(mis8), .mis_cnt(mc8)
  );

  jk_monitor #(.CNT_W(3), .LEN_W(3)) dut3 (
    .clk(clk), .rstn(rstn), .j(j), .k(k), .q(q), .clr(clr),
    .rise(rise3), .fall(fall3), .toggle_cnt(tog3), .high_len(hl3),
    .mismatch(mis3), .mis_cnt(mc3)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_rise   = 0;
  int n_fall   = 0;
  logic fq = 1'b0;  // state of the modelled flop driving q

  // Reference model: previous sample, unsaturated event counts, current high streak.
  logic m_valid = 1'b0, m_pj = 1'b0, m_pk = 1'b0, m_pq = 1'b0;
  logic m_rise = 1'b0, m_fall = 1'b0, m_mis = 1'b0;
  int unsigned m_tog = 0, m_misn = 0, m_hl = 0;
  logic hq[$];

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic ff_next(input logic jj, input logic kk, input logic qq);
    if (jj && kk) return !qq;
    if (jj) return 1'b1;
    if (kk) return 1'b0;
    return qq;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic c, input logic jj, input logic kk,
                              input logic qq);
    logic expq;
    if (!r) begin
      m_valid = 0; m_pj = 0; m_pk = 0; m_pq = 0;
      m_rise = 0; m_fall = 0; m_mis = 0;
      m_tog = 0; m_misn = 0; m_hl = 0;
      hq.delete();
    end else begin
      m_rise = m_valid && qq && !m_pq;
      m_fall = m_valid && !qq && m_pq;
      expq = ff_next(m_pj, m_pk, m_pq);
      if (c) begin
        m_tog = 0; m_hl = 0; m_mis = 0; m_misn = 0;
        hq.delete();
      end else if (m_valid) begin
        if (qq != m_pq) m_tog++;
        if (qq != expq) begin
          m_mis = 1;
          m_misn++;
        end
        if (qq) hq.push_back(1'b1);
        else begin
          if (m_pq) m_hl = hq.size();
          hq.delete();
        end
      end
      m_pj = jj; m_pk = kk; m_pq = qq; m_valid = 1;
    end
  endtask

  task automatic tick(input logic r, input logic c, input logic jj, input logic kk,
                      input logic qq);
    rstn = r; clr = c; j = jj; k = kk; q = qq;
    @(posedge clk);
    model_update(r, c, jj, kk, qq);
    #1;
    check("rise8", rise8, m_rise);
    check("fall8", fall8, m_fall);
    check("tog8", tog8, sat(m_tog, 255));
    check("hl8", hl8, sat(m_hl, 255));
    check("mis8", mis8, m_mis);
    check("mc8", mc8, sat(m_misn, 255));
    check("rise3", rise3, m_rise);
    check("fall3", fall3, m_fall);
    check("tog3", tog3, sat(m_tog, 7));
    check("hl3", hl3, sat(m_hl, 7));
    check("mis3", mis3, m_mis);
    check("mc3", mc3, sat(m_misn, 7));
    if (rise8) n_rise++;
    if (fall8) n_fall++;
  endtask

  task automatic flop_tick(input logic r, input logic c, input logic jj, input logic kk);
    tick(r, c, jj, kk, fq);
    fq = r ? ff_next(jj, kk, fq) : 1'b0;
  endtask

  typedef struct {
    logic r, c, j, k, q;
    logic er, ef;
    int unsigned tog, hl;
    logic em;
    int unsigned mc;
  } vec_t;

  vec_t tbl[13];

  initial begin
    //           r  c  j  k  q  rise fall tog hl mis mc
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0};
    tbl[5]  = '{1, 0, 1, 1, 1, 1, 0, 3, 2, 1, 1};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 1, 4, 1, 1, 1};
    tbl[7]  = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1};

    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].r, tbl[i].c, tbl[i].j, tbl[i].k, tbl[i].q);
      check($sformatf("tbl%0d.rise", i), rise8, tbl[i].er);
      check($sformatf("tbl%0d.fall", i), fall8, tbl[i].ef);
      check($sformatf("tbl%0d.tog", i), tog8, tbl[i].tog);
      check($sformatf("tbl%0d.hl", i), hl8, tbl[i].hl);
      check($sformatf("tbl%0d.mis", i), mis8, tbl[i].em);
      check($sformatf("tbl%0d.mc", i), mc8, tbl[i].mc);
    end

    // Reset then idle with the flop holding.
    flop_tick(0, 0, 0, 0);
    flop_tick(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) flop_tick(1, 0, 0, 0);
    check("idle.tog", tog8, 0);
    check("idle.mis", mis8, 0);

    // Set, hold three cycles, reset: one high run of four samples.
    flop_tick(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) flop_tick(1, 0, 0, 0);
    flop_tick(1, 0, 0, 1);
    flop_tick(1, 0, 0, 0);
    check("setrst.tog", tog8, 2);
    check("setrst.hl", hl8, 4);
    check("setrst.mis", mis8, 0);

    // Toggle mode for ten cycles.
    flop_tick(0, 0, 0, 0);
    flop_tick(1, 0, 0, 0);
    n_rise = 0;
    n_fall = 0;
    for (int i = 0; i < 10; i++) flop_tick(1, 0, 1, 1);
    flop_tick(1, 0, 0, 0);
    check("tgl.rises", n_rise, 5);
    check("tgl.falls", n_fall, 5);
    check("tgl.tog", tog8, 10);
    check("tgl.hl", hl8, 1);
    check("tgl.mis", mis8, 0);

    // Fault injection on a holding flop.
    flop_tick(0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    check("fault1.mis", mis8, 1);
    check("fault1.mc", mc8, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 1);
    check("fault1.sticky", mis8, 1);
    check("fault1.mc_hold", mc8, 1);
    tick(1, 0, 0, 0, 0);
    check("fault2.mc", mc8, 2);

    // Saturation of the 3-bit counters, then clear coinciding with a rise.
    fq = 1'b0;
    flop_tick(0, 0, 0, 0);
    flop_tick(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) flop_tick(1, 0, 1, 1);
    flop_tick(1, 0, 0, 0);
    check("sat.tog3", tog3, 7);
    check("sat.tog8", tog8, 12);
    tick(1, 1, 1, 0, 1);
    fq = 1'b1;
    check("clr.tog3", tog3, 0);
    check("clr.rise3", rise3, 1);
    flop_tick(1, 0, 0, 1);
    flop_tick(1, 0, 0, 0);
    check("clr.next_tog3", tog3, 1);
    check("clr.mis3", mis3, 0);

    // Reset in the middle of a high run.
    flop_tick(0, 0, 0, 0);
    flop_tick(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) flop_tick(1, 0, 0, 0);
    flop_tick(0, 0, 0, 0);
    flop_tick(1, 0, 0, 0);
    check("rstrun.hl", hl8, 0);
    check("rstrun.fall", fall8, 0);

    // Random traffic with occasional faults, clears and resets.
    for (int i = 0; i < 600; i++) begin
      logic r, c, jj, kk, flt;
      r   = ($urandom_range(63) != 0);
      c   = ($urandom_range(31) == 0);
      jj  = 1'($urandom_range(1));
      kk  = 1'($urandom_range(1));
      flt = ($urandom_range(15) == 0);
      tick(r, c, jj, kk, fq ^ flt);
      fq = r ? ff_next(jj, kk, fq) : 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
